// File: rtl/sram_arb_pkg.sv
// Shared types and sizing helpers for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_e;

  // Sizes for the default configuration; parameterized users call the helpers.
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_REQ_DEF    = 2;
  localparam int BM_WIDTH       = DATA_WIDTH_DEF / 8;
  localparam int IDX_WIDTH      = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

  function automatic int bm_width(input int dw);
    return dw / 8;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Round-robin picker: rotate by pointer, take lowest set bit, rotate back.
module sram_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;
  logic               found;

  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IDX_W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    idx = sum[IDX_W-1:0];
    gnt = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: round-robin with bounded grant locking and
// one-cycle response routing back to the accepted requester.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LOCK   = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0]                 req_lock_i,
  input  logic [NUM_REQ-1:0]                 req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_bm_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic                               rsp_we_o,
  output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
  output logic                               ram_en_o,
  output logic                               ram_wen_o,
  output logic [DATA_WIDTH/8-1:0]            ram_bm_o,
  output logic [ADDR_WIDTH-1:0]              ram_addr_o,
  output logic [DATA_WIDTH-1:0]              ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]              ram_rdata_i
);

  localparam int BM_W  = bm_width(DATA_WIDTH);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK) + 1;

  if (MAX_LOCK < 2) begin : g_bad_max_lock
    $error("sram_arbiter: MAX_LOCK must be >= 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sram_arbiter: NUM_REQ must be 2..8");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [IDX_W-1:0]   pick_idx, gnt_idx, rsp_owner_q;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] pick_gnt, gnt, owner_oh;
  logic               xfer, rsp_pend_q, rsp_we_q;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  sram_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    owner_oh   = NUM_REQ'(1) << owner_q;
    gnt        = (state_q == LOCKED) ? (owner_oh & req_valid_i) : pick_gnt;
    gnt_idx    = (state_q == LOCKED) ? owner_q : pick_idx;
    xfer       = |gnt;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          if (|(gnt & req_lock_i)) begin
            state_d    = LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = ptr_inc(gnt_idx);
          end
        end
      end
      LOCKED: begin
        // Release on unlock, on reaching the tenure cap, or when the owner walks away.
        if (xfer) begin
          if (!(|(gnt & req_lock_i)) || lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
            state_d    = ARB;
            rr_ptr_d   = ptr_inc(owner_q);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else if (!(|(owner_oh & (req_valid_i | req_lock_i)))) begin
          state_d    = ARB;
          rr_ptr_d   = ptr_inc(owner_q);
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // SRAM mux: everything is zero unless a transfer is in flight.
  always_comb begin
    ram_en_o    = xfer;
    ram_wen_o   = 1'b0;
    ram_bm_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_wen_o   = req_we_i[i];
        ram_bm_o    = req_bm_i[i*BM_W +: BM_W];
        ram_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_pend_q <= xfer;
      if (xfer) begin
        rsp_owner_q <= gnt_idx;
        rsp_we_q    <= ram_wen_o;
      end
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_pend_q ? (NUM_REQ'(1) << rsp_owner_q) : '0;
  assign rsp_we_o    = rsp_pend_q & rsp_we_q;
  assign rsp_rdata_o = (rsp_pend_q && !rsp_we_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter against a rule-level reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int BW = BM_WIDTH;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    v, l, w;
  logic [AW-1:0]   a  [N];
  logic [BW-1:0]   bm [N];
  logic [DW-1:0]   wd [N];
  logic [N*AW-1:0] a_flat;
  logic [N*BW-1:0] bm_flat;
  logic [N*DW-1:0] wd_flat;

  logic [N-1:0]  ready, rsp_valid;
  logic          rsp_we, ram_en, ram_wen;
  logic [DW-1:0] rsp_rdata, ram_wdata, ram_rdata;
  logic [BW-1:0] ram_bm;
  logic [AW-1:0] ram_addr;

  always_comb begin
    a_flat  = '0;
    bm_flat = '0;
    wd_flat = '0;
    for (int i = 0; i < N; i++) begin
      a_flat[i*AW +: AW]  = a[i];
      bm_flat[i*BW +: BW] = bm[i];
      wd_flat[i*DW +: DW] = wd[i];
    end
  end

  sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (v),
    .req_ready_o (ready),
    .req_lock_i  (l),
    .req_we_i    (w),
    .req_addr_i  (a_flat),
    .req_bm_i    (bm_flat),
    .req_wdata_i (wd_flat),
    .rsp_valid_o (rsp_valid),
    .rsp_we_o    (rsp_we),
    .rsp_rdata_o (rsp_rdata),
    .ram_en_o    (ram_en),
    .ram_wen_o   (ram_wen),
    .ram_bm_o    (ram_bm),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] m);
    logic [DW-1:0] r;
    for (int b = 0; b < BW; b++) r[b*8 +: 8] = m[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Behavioural SRAM: command captured mid-cycle, executed on the next rising edge.
  logic [DW-1:0] mem [128] = '{default: '0};
  logic          cap_en = 1'b0, cap_wen = 1'b0;
  logic [BW-1:0] cap_bm;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wd;
  initial ram_rdata = '0;

  always @(negedge clk) begin
    cap_en   <= ram_en;
    cap_wen  <= ram_wen;
    cap_bm   <= ram_bm;
    cap_addr <= ram_addr;
    cap_wd   <= ram_wdata;
  end

  always @(posedge clk) begin
    if (cap_en) begin
      if (cap_wen) mem[cap_addr[9:3]] <= merge(mem[cap_addr[9:3]], cap_wd, cap_bm);
      else         ram_rdata <= mem[cap_addr[9:3]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            owner;
    logic          we;
    logic [DW-1:0] rdata;
    int            due;
  } rsp_t;
  rsp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: arbitration and lock tenure in terms of the stated rules.
  logic [DW-1:0] ref_mem [128] = '{default: '0};
  bit   m_locked = 1'b0;
  int   m_owner = 0, m_ptr = 0, m_tenure = 0;
  int   chk_g;
  logic [N+2+BW+AW+DW-1:0] exp_bus, act_bus;

  initial forever begin
    @(negedge clk);
    chk_g = -1;
    if (m_locked) begin
      if (v[m_owner]) chk_g = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (chk_g < 0 && v[(m_ptr + k) % N]) chk_g = (m_ptr + k) % N;
    end
    exp_bus = '0;
    if (chk_g >= 0) exp_bus = {oh(chk_g), 1'b1, w[chk_g], bm[chk_g], a[chk_g], wd[chk_g]};
    act_bus = {ready, ram_en, ram_wen, ram_bm, ram_addr, ram_wdata};
    vectors++;
    if (act_bus !== exp_bus) begin
      miscompares++;
      $display("FAIL grant_sram cyc=%0d got=%h exp=%h", cyc, act_bus, exp_bus);
    end
    if (chk_g >= 0) begin
      if (rst_n)
        q.push_back('{owner: chk_g, we: w[chk_g],
                      rdata: w[chk_g] ? '0 : ref_mem[a[chk_g][9:3]], due: cyc + 1});
      if (w[chk_g]) ref_mem[a[chk_g][9:3]] = merge(ref_mem[a[chk_g][9:3]], wd[chk_g], bm[chk_g]);
    end
    if (!m_locked) begin
      if (chk_g >= 0) begin
        if (l[chk_g]) begin
          m_locked = 1'b1; m_owner = chk_g; m_tenure = 1;
        end else begin
          m_ptr = (chk_g + 1) % N;
        end
      end
    end else if (chk_g >= 0) begin
      m_tenure++;
      if (!l[chk_g] || m_tenure == ML) begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
      end
    end else if (!l[m_owner]) begin
      m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
    end
    if (!rst_n) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_tenure = 0;
    end
  end

  // Response monitor: anything due this cycle must appear, otherwise silence.
  rsp_t mon_e;
  initial forever begin
    @(negedge clk);
    vectors++;
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e = q.pop_front();
      if (rsp_valid !== oh(mon_e.owner) || rsp_we !== mon_e.we || rsp_rdata !== mon_e.rdata) begin
        miscompares++;
        $display("FAIL rsp cyc=%0d got v=%b we=%b d=%h exp v=%b we=%b d=%h", cyc, rsp_valid,
                 rsp_we, rsp_rdata, oh(mon_e.owner), mon_e.we, mon_e.rdata);
      end
    end else if (rsp_valid !== '0 || rsp_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_idle cyc=%0d got v=%b we=%b exp v=0 we=0", cyc, rsp_valid, rsp_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v = '0; l = '0; w = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0; bm[i] = '0; wd[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic vv, input logic ll, input logic ww,
                         input logic [AW-1:0] aa, input logic [BW-1:0] mm, input logic [DW-1:0] dd);
    v[i] = vv; l[i] = ll; w[i] = ww; a[i] = aa; bm[i] = mm; wd[i] = dd;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Seed two lines through requester 2, then contend with reads on 0 and 1.
    set_req(2, 1, 0, 1, 32'h100, 8'hFF, 64'h0123_4567_89AB_CDEF); tick();
    set_req(2, 1, 0, 1, 32'h200, 8'hFF, 64'hFEDC_BA98_7654_3210); tick();
    idle();
    set_req(0, 1, 0, 0, 32'h100, 8'h00, '0);
    set_req(1, 1, 0, 0, 32'h200, 8'h00, '0);
    repeat (4) tick();
    idle(); tick();

    // Partial write then read-back.
    set_req(0, 1, 0, 1, 32'h40, 8'h0F, 64'hDEAD_BEEF_0000_1111); tick();
    set_req(0, 1, 0, 0, 32'h40, 8'h00, '0); tick();
    idle(); tick();

    // Lock burst 1,1,(gap),1,0 while requester 1 keeps asking.
    set_req(1, 1, 0, 0, 32'h200, 8'h00, '0);
    set_req(0, 1, 1, 0, 32'h100, 8'h00, '0); tick();
    set_req(0, 1, 1, 1, 32'h108, 8'hF0, 64'hAAAA_5555_AAAA_5555); tick();
    set_req(0, 0, 1, 0, 32'h110, 8'h00, '0); tick();
    set_req(0, 1, 1, 0, 32'h108, 8'h00, '0); tick();
    set_req(0, 1, 0, 0, 32'h110, 8'h00, '0); tick();
    set_req(0, 0, 0, 0, '0, '0, '0); repeat (2) tick();

    // Forced release: requester 0 never drops lock.
    set_req(0, 1, 1, 0, 32'h40, 8'h00, '0);
    repeat (10) tick();
    idle(); tick();

    // Abandon: owner drops valid and lock.
    set_req(1, 1, 0, 0, 32'h100, 8'h00, '0);
    set_req(0, 1, 1, 0, 32'h108, 8'h00, '0); tick();
    set_req(0, 0, 0, 0, '0, '0, '0); repeat (2) tick();
    idle(); tick();

    // Reset while locked with a read being accepted.
    set_req(0, 1, 1, 0, 32'h40, 8'h00, '0); repeat (2) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 32'(i * 8), 8'h00, '0);
    repeat (3) tick();
    idle(); tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 127) * 8), BW'($urandom), {$urandom, $urandom});
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port SRAM datapath (en/wen/bm/addr/wdata/rdata, 1-cycle read latency) between NUM_REQ native requesters.
- Intended requesters: an AXI4 SRAM front-end, a DMA port and a debug port.
- Round-robin arbitration with optional grant locking for bursts, bounded by MAX_LOCK.
- Per-requester response routing. SRAM-side enables are active-high; inversion to tech active-low is done downstream.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width; byte mask is DATA_WIDTH/8
- MAX_LOCK, 16, maximum accepted transfers per locked tenure (>=2)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- req_valid_i  in  NUM_REQ  request valid per requester
- req_ready_o  out  NUM_REQ  request accepted (grant)
- req_lock_i  in  NUM_REQ  hold grant after this transfer
- req_we_i  in  NUM_REQ  1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses
- req_bm_i  in  NUM_REQ*DATA_WIDTH/8  packed byte masks
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid_o  out  NUM_REQ  response pulse, one cycle after acceptance
- rsp_we_o  out  1  response is write ack
- rsp_rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters
- ram_en_o  out  1  SRAM access enable
- ram_wen_o  out  1  SRAM write enable
- ram_bm_o  out  DATA_WIDTH/8  SRAM byte mask
- ram_addr_o  out  ADDR_WIDTH  SRAM address
- ram_wdata_o  out  DATA_WIDTH  SRAM write data
- ram_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after en & !wen

Behaviour:
- Single clock; reset is synchronous, active-low on rst_n_i.
- Reset state:
  - state=ARB, rr_ptr_q=0, owner_q=0, lock_cnt_q=0, rsp_pend_q=0.
  - Hence rsp_valid_o=0, rsp_we_o=0. With no valid input, req_ready_o=0 and ram_en_o=0.
- Reset mid-transfer discards the pending response and any lock.
- Grant is combinational, so zero-latency acceptance.
- ARB state:
  - Grant the first valid requester scanning from rr_ptr_q upward, modulo NUM_REQ.
  - gnt is one-hot or zero; req_ready_o=gnt.
- LOCKED state:
  - Only owner_q can be granted; all other ready bits are 0.
  - Idle cycles are allowed while the owner is not valid.
- Transfer: req_valid_i[i] & req_ready_o[i].
  - Same cycle: ram_en_o=1, and ram_wen/bm/addr/wdata come from requester i.
  - ram_en_o = |gnt.
  - When ram_en_o=0, the other SRAM outputs are 0.
- Pointer update: rr_ptr_q <= (i+1) mod NUM_REQ on any transfer that leaves or keeps the FSM in ARB, and on lock release.
- FSM transitions:
  - ARB -> LOCKED: transfer with req_lock_i[i]=1. Sets owner_q=i, lock_cnt_q=1.
  - LOCKED -> LOCKED: owner transfer with lock=1 and lock_cnt_q<MAX_LOCK-1. Increments lock_cnt_q.
  - LOCKED -> ARB on owner transfer with lock=0: normal release.
  - LOCKED -> ARB on owner transfer when lock_cnt_q==MAX_LOCK-1: forced release. The transfer still completes; the pointer advances so others get a turn.
  - LOCKED -> ARB when req_valid_i[owner]=0 and req_lock_i[owner]=0: abandon, no transfer, pointer advances.
- Response:
  - On a transfer, register rsp_pend_q=1, rsp_owner_q=i, rsp_we_q=we.
  - Next cycle: rsp_valid_o[rsp_owner_q]=1, rsp_we_o=rsp_we_q, rsp_rdata_o=ram_rdata_i (0 when rsp_we_q=1).
  - No response backpressure; requesters must sink every response. Back-to-back transfers produce back-to-back responses.
- Simultaneous requests:
  - Exactly one grant.
  - Requests not granted must stay stable (AXI-like valid rule); the arbiter does not check this.
- Address, width and lock-mode rules:
  - No address translation. The address passes through unchanged; base subtraction and bank select stay downstream.
  - req_lock_i of a non-granted requester is ignored.
  - In ARB, a lock request whose transfer completes with MAX_LOCK==1 is illegal; this is guarded by a parameter assertion.

Decomposition:
- Shared package sram_arb_pkg:
  - state enum arb_state_e {ARB, LOCKED}
  - localparams BM_WIDTH=DATA_WIDTH/8 and IDX_WIDTH=$clog2(NUM_REQ) (min 1)
- One sub-module sram_rr_pick:
  - Combinational round-robin picker: inputs req vector and pointer; outputs one-hot gnt and index.
  - Implemented via rotate, priority-encode, rotate-back.
- The top holds the FSM, lock counter, pointer, response pipeline and SRAM mux.

Test Plan:
- Reset then idle: all valid=0 -> req_ready_o=0, ram_en_o=0, rsp_valid_o=0. After reset, rr_ptr selects req0 first.
- Contention, NUM_REQ=2, both valid reads, addr0=0x100, addr1=0x200, 4 cycles:
  - Grants alternate 0,1,0,1.
  - Each rsp_valid_o one cycle later carries the SRAM model data for that address.
- Write then read, same requester:
  - Write 0xDEAD_BEEF_0000_1111 with bm=0x0F to 0x40, then read 0x40.
  - Expect rsp_we_o=1 ack, then rdata=0x0000_0000_0000_1111 from a zero-init model.
- Lock burst: req0 issues 4 transfers with lock=1,1,1,0 while req1 holds valid.
  - req1 ready stays 0 for 4 accepted transfers plus any owner gaps.
  - req1 is granted on the cycle after release.
- Forced release: MAX_LOCK=4, req0 holds lock=1 continuously.
  - After 4 accepted transfers the FSM returns to ARB and req1 is granted next.
- Abandon and reset mid-lock:
  - Owner drops valid and lock -> the next cycle grants the other requester.
  - rst_n_i=0 during LOCKED with a read pending -> no rsp_valid_o the next cycle; state ARB, ptr 0.
